lane_training_sequencer: RTL



---
 rtl/usb4_train_pkg.sv | 48 ++++
 rtl/lane_os_counter.sv | 31 +++
 rtl/lane_training_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/usb4_train_pkg.sv
// Shared OS / d_sel encoding, training state enum and state-walk helpers used by
// the lane training sequencer and the data bus transmit/receive blocks.
package usb4_train_pkg;

  localparam logic [3:0] OS_NONE  = 4'd0;
  localparam logic [3:0] OS_SLOS1 = 4'd1;
  localparam logic [3:0] OS_SLOS2 = 4'd2;
  localparam logic [3:0] OS_TS1   = 4'd3;
  localparam logic [3:0] OS_TS2   = 4'd4;
  localparam logic [3:0] OS_DATA  = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SLOS1 = 3'd1,
    ST_SLOS2 = 3'd2,
    ST_TS1   = 3'd3,
    ST_TS2   = 3'd4,
    ST_CL0   = 3'd5
  } train_state_t;

  function automatic train_state_t next_state_of(input train_state_t s);
    case (s)
      ST_SLOS1: return ST_SLOS2;
      ST_SLOS2: return ST_TS1;
      ST_TS1:   return ST_TS2;
      ST_TS2:   return ST_CL0;
      default:  return s;
    endcase
  endfunction

  function automatic logic [3:0] os_code(input train_state_t s);
    case (s)
      ST_SLOS1: return OS_SLOS1;
      ST_SLOS2: return OS_SLOS2;
      ST_TS1:   return OS_TS1;
      ST_TS2:   return OS_TS2;
      ST_CL0:   return OS_DATA;
      default:  return OS_NONE;
    endcase
  endfunction

  // The partner lane may be one training state ahead; nothing follows TS2 on the wire.
  function automatic logic [3:0] succ_os(input train_state_t s);
    if (s == ST_TS2) return OS_NONE;
    return os_code(next_state_of(s));
  endfunction

endpackage

// File: rtl/lane_os_counter.sv
// Per-lane count of consecutive accepted ordered sets, saturating at RX_MIN.
module lane_os_counter
  import usb4_train_pkg::*;
#(
  parameter int RX_MIN = 8,
  parameter int CW     = $clog2(RX_MIN + 1)
) (
  input  logic          fsm_clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [3:0]    expected,
  input  logic [3:0]    successor,
  input  logic [3:0]    os_in,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] CNT_MAX = CW'(RX_MIN);

  always_ff @(posedge fsm_clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (os_in != OS_NONE) begin
      if (os_in == expected || os_in == successor) begin
        if (cnt < CNT_MAX) cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lane_training_sequencer.sv
// Walks the dual-lane bus through SLOS1 -> SLOS2 -> TS1 -> TS2 -> CL0 on OS counts,
// dropping back to IDLE on abort (start low) or on a per-state timeout.
module lane_training_sequencer
  import usb4_train_pkg::*;
#(
  parameter int TX_MIN      = 16,
  parameter int RX_MIN      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       fsm_clk,
  input  logic       rst,
  input  logic       start,
  input  logic       os_sent,
  input  logic [3:0] os_in_l0,
  input  logic [3:0] os_in_l1,
  output logic [3:0] d_sel,
  output logic       data_os,
  output logic       lane_rx_on,
  output logic       training_done,
  output logic       training_err,
  output logic [2:0] state
);
  // state | meaning
  // IDLE  | lanes off, waiting for start
  // SLOS1 | sending/receiving SLOS1
  // SLOS2 | sending/receiving SLOS2
  // TS1   | sending/receiving TS1
  // TS2   | sending/receiving TS2
  // CL0   | trained, transport data flows

  localparam int TXW = $clog2(TX_MIN + 1);
  localparam int RXW = $clog2(RX_MIN + 1);
  localparam int TMW = $clog2(TIMEOUT_CYC);
  localparam logic [TXW-1:0] TX_FULL  = TXW'(TX_MIN);
  localparam logic [RXW-1:0] RX_FULL  = RXW'(RX_MIN);
  localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT_CYC - 1);

  train_state_t cur, nxt;
  logic [TXW-1:0] tx_cnt;
  logic [RXW-1:0] rx_cnt_l0, rx_cnt_l1;
  logic [TMW-1:0] tmo_cnt;
  logic training, advance, tmo_fire, xfer, cnt_clear;

  assign training  = (cur inside {ST_SLOS1, ST_SLOS2, ST_TS1, ST_TS2});
  assign advance   = (tx_cnt >= TX_FULL) && (rx_cnt_l0 >= RX_FULL) && (rx_cnt_l1 >= RX_FULL);
  assign xfer      = (nxt != cur);
  assign cnt_clear = xfer || !training;

  always_ff @(posedge fsm_clk) begin
    if (rst) cur <= ST_IDLE;
    else     cur <= nxt;
  end

  // Abort beats advance, and advance beats timeout.
  always_comb begin
    nxt      = cur;
    tmo_fire = 1'b0;
    case (cur)
      ST_IDLE: if (start) nxt = ST_SLOS1;
      ST_CL0:  if (!start) nxt = ST_IDLE;
      default: begin
        if (!start) begin
          nxt = ST_IDLE;
        end else if (advance) begin
          nxt = next_state_of(cur);
        end else if (tmo_cnt == TMO_LAST) begin
          nxt      = ST_IDLE;
          tmo_fire = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge fsm_clk) begin
    if (rst || cnt_clear) begin
      tx_cnt  <= '0;
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMW'(1);
      if (os_sent && tx_cnt < TX_FULL) tx_cnt <= tx_cnt + TXW'(1);
    end
  end

  lane_os_counter #(.RX_MIN(RX_MIN), .CW(RXW)) u_cnt_l0 (
    .fsm_clk   (fsm_clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .expected  (os_code(cur)),
    .successor (succ_os(cur)),
    .os_in     (os_in_l0),
    .cnt       (rx_cnt_l0)
  );

  lane_os_counter #(.RX_MIN(RX_MIN), .CW(RXW)) u_cnt_l1 (
    .fsm_clk   (fsm_clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .expected  (os_code(cur)),
    .successor (succ_os(cur)),
    .os_in     (os_in_l1),
    .cnt       (rx_cnt_l1)
  );

  always_ff @(posedge fsm_clk) begin
    if (rst) begin
      d_sel         <= OS_NONE;
      data_os       <= 1'b1;
      lane_rx_on    <= 1'b0;
      training_done <= 1'b0;
      training_err  <= 1'b0;
    end else begin
      d_sel         <= os_code(cur);
      data_os       <= (cur != ST_CL0);
      lane_rx_on    <= (cur != ST_IDLE);
      training_done <= (cur == ST_CL0);
      training_err  <= tmo_fire;
    end
  end

  assign state = cur;

endmodule
